// File: rtl/mips_instr_encoder.sv
// Program loader: packs symbolic MIPS instruction fields from a valid/ready stream
// into 32-bit words and writes them to instruction memory at consecutive addresses.
module mips_instr_encoder #(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              full,
    output logic              err_illegal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FULL = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_BEQ  = 4'd7;
    localparam logic [3:0] OP_ADDI = 4'd8;
    localparam logic [3:0] OP_J    = 4'd9;

    function automatic logic is_legal(input logic [3:0] op);
        return (op <= OP_J);
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'b000000, rs, rt, rd, 5'b00000, funct};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    function automatic logic [31:0] encode(input logic [3:0]  op,
                                           input logic [4:0]  rs,
                                           input logic [4:0]  rt,
                                           input logic [4:0]  rd,
                                           input logic [15:0] imm,
                                           input logic [25:0] target);
        logic [31:0] w;
        w = 32'h0;
        case (op)
            OP_ADD:  w = rtype(rs, rt, rd, 6'b100000);
            OP_SUB:  w = rtype(rs, rt, rd, 6'b100010);
            OP_AND:  w = rtype(rs, rt, rd, 6'b100100);
            OP_OR:   w = rtype(rs, rt, rd, 6'b100101);
            OP_SLT:  w = rtype(rs, rt, rd, 6'b101010);
            OP_LW:   w = itype(6'b100011, rs, rt, imm);
            OP_SW:   w = itype(6'b101011, rs, rt, imm);
            OP_BEQ:  w = itype(6'b000100, rs, rt, imm);
            OP_ADDI: w = itype(6'b001000, rs, rt, imm);
            OP_J:    w = {6'b000010, target};
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    state_t              state_q;
    state_t              state_d;
    logic                accept_p0;
    logic                legal_p0;
    logic                last_p0;
    logic [31:0]         word_p0;

    logic                we_p1;
    logic [ADDR_W-1:0]   addr_p1;
    logic [31:0]         wdata_p1;
    logic [ADDR_W:0]     cnt_p1;
    logic                err_p1;

    // p0: handshake and combinational encode of the presented fields
    always_comb begin
        in_ready  = (state_q == RUN);
        busy      = (state_q == RUN) || (state_q == FULL);
        full      = (state_q == FULL);
        accept_p0 = in_valid && in_ready;
        legal_p0  = accept_p0 && is_legal(in_op);
        last_p0   = legal_p0 && (cnt_p1 == LAST_CNT);
        word_p0   = encode(in_op, in_rs, in_rt, in_rd, in_imm, in_target);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                // finish wins over filling the last slot; both close the stream
                if (finish)       state_d = IDLE;
                else if (last_p0) state_d = FULL;
            end
            FULL: if (finish) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // p1: registered IMEM write port and session bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            we_p1    <= 1'b0;
            addr_p1  <= BASE;
            wdata_p1 <= 32'h0;
            cnt_p1   <= '0;
            err_p1   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_p1   <= legal_p0;
            if (state_q == IDLE && start) begin
                addr_p1 <= BASE;
                cnt_p1  <= '0;
                err_p1  <= 1'b0;
            end
            if (legal_p0) begin
                addr_p1  <= BASE + cnt_p1[ADDR_W-1:0];
                wdata_p1 <= word_p0;
                cnt_p1   <= cnt_p1 + CNT_ONE;
            end else if (accept_p0) begin
                err_p1 <= 1'b1;
            end
        end
    end

    assign imem_we     = we_p1;
    assign imem_addr   = addr_p1;
    assign imem_wdata  = wdata_p1;
    assign word_count  = cnt_p1;
    assign err_illegal = err_p1;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for mips_instr_encoder: stimulus pushes expected writes into a queue,
// a negedge monitor pops and compares every IMEM write.
module tb_mips_instr_encoder;

    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              finish;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   word_count;
    logic              busy;
    logic              full;
    logic              err_illegal;

    mips_instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0), .DEPTH(64)) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_target(in_target), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .word_count(word_count), .busy(busy),
        .full(full), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [ADDR_W:0]   cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every write must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (imem_we === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write_addr", 64'(imem_addr), 64'hFFFF);
                end else begin
                    e = sb.pop_front();
                    chk("write_addr", 64'(imem_addr), 64'(e.addr));
                    chk("write_data", 64'(imem_wdata), 64'(e.wdata));
                    chk("write_count", 64'(word_count), 64'(e.cnt));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_finish();
        finish = 1'b1;
        tick();
        finish = 1'b0;
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                        input logic [31:0] word, input int addr, input bit wr, input bit fin);
        exp_t e;
        in_valid  = 1'b1;
        in_op     = op;
        in_rs     = rs;
        in_rt     = rt;
        in_rd     = rd;
        in_imm    = imm;
        in_target = tgt;
        finish    = fin;
        if (wr) begin
            e.addr  = ADDR_W'(addr);
            e.wdata = word;
            e.cnt   = (ADDR_W+1)'(addr + 1);
            sb.push_back(e);
        end
        tick();
        in_valid = 1'b0;
        finish   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
        tick();
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_we", 64'(imem_we), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_err", 64'(err_illegal), 64'd0);
        chk("rst_addr", 64'(imem_addr), 64'd0);
        chk("rst_wdata", 64'(imem_wdata), 64'd0);
        chk("rst_count", 64'(word_count), 64'd0);
        rst = 1'b0;
        tick();

        // Single ADD
        pulse_start();
        chk("run_busy", 64'(busy), 64'd1);
        chk("run_in_ready", 64'(in_ready), 64'd1);
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h00221820, 0, 1'b1, 1'b0);
        tick();
        pulse_finish();
        chk("idle_busy", 64'(busy), 64'd0);

        // Back-to-back I/J types, then more R-types around an illegal op
        pulse_start();
        send(4'd5, 5'd0, 5'd8, 5'd0, 16'h0004, 26'h0, 32'h8C080004, 0, 1'b1, 1'b0);
        send(4'd7, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 32'h1022FFFF, 1, 1'b1, 1'b0);
        send(4'd8, 5'd0, 5'd9, 5'd0, 16'h0005, 26'h0, 32'h20090005, 2, 1'b1, 1'b0);
        send(4'd9, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 32'h08000010, 3, 1'b1, 1'b0);
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h00221820, 4, 1'b1, 1'b0);
        send(4'd12, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0, 0, 1'b0, 1'b0);
        send(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 32'h00853022, 5, 1'b1, 1'b0);
        send(4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h00221824, 6, 1'b1, 1'b0);
        send(4'd3, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h00221825, 7, 1'b1, 1'b0);
        send(4'd4, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0, 32'h00E8482A, 8, 1'b1, 1'b0);
        chk("err_set", 64'(err_illegal), 64'd1);
        tick();
        tick();
        chk("err_sticky", 64'(err_illegal), 64'd1);
        chk("count_after_illegal", 64'(word_count), 64'd9);
        pulse_finish();
        pulse_start();
        chk("err_cleared", 64'(err_illegal), 64'd0);
        chk("count_cleared", 64'(word_count), 64'd0);

        // Fill all 64 slots
        for (int i = 0; i < 64; i++) begin
            send(4'd8, 5'd0, 5'd1, 5'd0, 16'(i), 26'h0, 32'h20010000 | 32'(i), i, 1'b1, 1'b0);
        end
        chk("full_flag", 64'(full), 64'd1);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_busy", 64'(busy), 64'd1);
        in_valid = 1'b1;
        in_op    = 4'd0;
        for (int i = 0; i < 4; i++) tick();
        in_valid = 1'b0;
        chk("full_count", 64'(word_count), 64'd64);
        chk("full_last_addr", 64'(imem_addr), 64'd63);
        pulse_finish();
        chk("full_finish_busy", 64'(busy), 64'd0);
        chk("full_finish_full", 64'(full), 64'd0);

        // finish coincident with an accepted SW
        pulse_start();
        send(4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h00221824, 0, 1'b1, 1'b0);
        send(4'd6, 5'd2, 5'd3, 5'd0, 16'h0008, 26'h0, 32'hAC430008, 1, 1'b1, 1'b1);
        chk("fin_beat_busy", 64'(busy), 64'd0);
        tick();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        chk("idle_hold_count", 64'(word_count), 64'd2);
        chk("idle_hold_addr", 64'(imem_addr), 64'd1);

        // Reset hits the edge that would accept a beat: the write is dropped
        pulse_start();
        in_valid = 1'b1;
        in_op    = 4'd3;
        rst      = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("rst_mid_we", 64'(imem_we), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_count", 64'(word_count), 64'd0);
        chk("rst_mid_addr", 64'(imem_addr), 64'd0);
        chk("rst_mid_wdata", 64'(imem_wdata), 64'd0);
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk("pending_writes", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
